// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/
// execute/memory/write-back and drives Moore control outputs from registers.
module mips_multicycle_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] Op,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [3:0] state,
    output logic       bad_op
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd2;

    typedef enum logic [3:0] {
        S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3, S4 = 4'd4,
        S5 = 4'd5, S6 = 4'd6, S7 = 4'd7, S8 = 4'd8, S9 = 4'd9
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_t;

    state_t state_q;
    state_t next_state;
    logic   next_bad;
    ctrl_t  ctrl_q;

    // Control word for a given state; unlisted fields and illegal states are 0.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S0: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            S1: c.alu_src_b = 2'b11;
            S2: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S3: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S4: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S5: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S6: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S7: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S8: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S9: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Op is only consulted when leaving Decode and MemAddr.
    always_comb begin
        next_state = S0;
        next_bad   = 1'b0;
        case (state_q)
            S0: next_state = S1;
            S1: begin
                case (Op)
                    OP_LW, OP_SW: next_state = S2;
                    OP_RTYPE:     next_state = S6;
                    OP_BEQ:       next_state = S8;
                    OP_J:         next_state = S9;
                    default:      next_bad   = 1'b1;
                endcase
            end
            S2: begin
                case (Op)
                    OP_LW:   next_state = S3;
                    OP_SW:   next_state = S5;
                    default: next_bad   = 1'b1;
                endcase
            end
            S3: next_state = S4;
            S6: next_state = S7;
            default: next_state = S0;
        endcase
    end

    // Outputs are registered from the next state so they always match state_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S0;
            ctrl_q  <= decode(S0);
            bad_op  <= 1'b0;
        end else begin
            state_q <= next_state;
            ctrl_q  <= decode(next_state);
            bad_op  <= next_bad;
        end
    end

    assign state       = state_q;
    assign PCWrite     = ctrl_q.pc_write;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.i_or_d;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign IRWrite     = ctrl_q.ir_write;
    assign PCSource    = ctrl_q.pc_source;
    assign ALUOp       = ctrl_q.alu_op;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign RegWrite    = ctrl_q.reg_write;
    assign RegDst      = ctrl_q.reg_dst;

endmodule
